id_ex_ctrl_pipe: RTL
====================

Name: id_ex_ctrl_pipe

Overview:
- Pipelined successor to the single-cycle main decoder; sits between the IF/ID register and the EX stage of the 5-stage MIPS core.
- Decodes the ID-stage instruction into the full control bundle and registers it, with the register addresses, into the ID/EX control register.
- Detects load-use hazards and inserts a parametrised number of bubbles, with stall outputs to PC and IF/ID.
- Handles flush and global hold, and flags illegal opcodes with a saturating counter.

Parameters:
- ALU_OP_W, 4: width of the ALU op field. Must be ≥4; codes are zero-extended.
- LOAD_LAT, 1: bubbles required after a load before a dependent instruction may enter EX. Legal range 1..3.
- CNT_W, 8: width of the illegal-opcode counter.
- LINK_REG, 31: destination register for jal.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: asynchronous reset, active-high.
- id_instr_i in 32: ID-stage instruction. Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6].
- id_valid_i in 1: ID instruction is real (not a bubble).
- flush_i in 1: branch/jump resolved taken; kill the ID instruction.
- hold_i in 1: global freeze (memory wait).
- err_clr_i in 1: clear illegal_o and illegal_cnt_o.
- stall_o out 1: freeze PC and IF/ID this cycle.
- ex_valid_o out 1: EX holds a real instruction.
- ex_reg_write_o, ex_alu_src_o, ex_branch_o, ex_jump_o, ex_jal_o, ex_zero_ext_o, ex_lui_o, ex_sltiu_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o out 1 each: registered control bits.
- ex_alu_op_o out ALU_OP_W: registered ALU op.
- ex_shamt_o out 5: shamt for R-type, else 0.
- ex_rs_o, ex_rt_o, ex_wr_reg_o out 5 each: source registers and final destination register.
- illegal_o out 1: sticky illegal-opcode flag.
- illegal_cnt_o out CNT_W: saturating count of illegal opcodes.

Behaviour:
- Reset: every output register clears to 0, state goes to IDLE, the counter clears to 0. stall_o is 0 while rst_i is high.
- Decode is combinational; the op field selects the control bits as follows.
  - 000000 R-type: ALU op 0000, reg_write, destination rd, rt is a source.
  - 001000 addi: ALU op 0001, alu_src, reg_write, destination rt.
  - 000100 beq: ALU op 0010, branch, rt is a source.
  - 000101 bne: ALU op 0011, branch, rt is a source.
  - 001111 lui: ALU op 0100, alu_src, reg_write, lui.
  - 001101 ori: ALU op 0101, alu_src, reg_write, zero_ext.
  - 001011 sltiu: ALU op 0110, alu_src, reg_write, zero_ext, sltiu.
  - 000010 j: ALU op 0111, jump.
  - 000011 jal: ALU op 1000, jump, jal, reg_write, destination LINK_REG.
  - 000110 blez: ALU op 1110, branch.
  - 000111 bgtz: ALU op 1111, branch.
  - 100011 lw: ALU op 1010, alu_src, reg_write, mem_read, mem_to_reg, destination rt.
  - 101011 sw: ALU op 1011, alu_src, mem_write, rt is a source.
  - Every unlisted control bit is 0; there are no X outputs.
- Destination register for non-writing instructions is 0.
- Illegal opcode: any other op with id_valid_i=1 decodes to an all-zero bundle and enters EX as a bubble (ex_valid_o=0). It is counted only on a cycle where ID/EX actually loads (not hold, stall or flush).
- Hazard detection:
  - hz = ex_valid_o & ex_mem_read_o & ex_wr_reg_o≠0 & id_valid_i & (ex_wr_reg_o==rs | (rt_is_src & ex_wr_reg_o==rt)).
  - rt_is_src is 1 for R-type, beq, bne and sw.
- FSM states are IDLE and STALL; cnt is a 2-bit counter.
  - IDLE & hz & !flush_i & !hold_i: stall_o=1; ID/EX loads a bubble. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - STALL: stall_o=1; ID/EX loads a bubble and cnt decrements. Return to IDLE when cnt reaches 1 at the clock edge.
  - The ID instruction is re-evaluated in IDLE.
- Priority per clock edge is reset > flush_i > hold_i > stall > normal load.
  - flush_i: ID/EX loads a bubble and the FSM goes to IDLE. stall_o=0 when flush_i=1.
  - hold_i: ID/EX, the FSM, cnt and the counter all keep their values. stall_o=1 during hold_i.
  - Normal load: ID/EX takes the decoded bundle, and ex_valid_o=id_valid_i & legal.
- A bubble has every control bit 0, ex_valid_o=0, and registers 0.
- Latency: decode appears on ex_* one cycle after the ID-stage load.
- Counter:
  - illegal_cnt_o saturates at all-ones.
  - illegal_o sets on the first count.
  - err_clr_i clears both. When err_clr_i and a new illegal opcode fall on the same edge, the result is count=1 and flag=1.

Test Plan:
- R-type add $3,$1,$2 then addi $4,$3,5, LOAD_LAT=1: ex_reg_write_o=1 and ex_wr_reg_o=3, then ex_alu_op_o=0001, ex_alu_src_o=1, ex_wr_reg_o=4; stall_o never asserts.
- lw $5,0($1) then add $6,$5,$2: with LOAD_LAT=1, stall_o=1 for exactly 1 cycle and one ex_valid_o=0 bubble, then the add enters. With LOAD_LAT=3, 3 stall cycles and 3 bubbles.
- lw $5 then sw $5,4($2) (rt source): stall occurs. lw $0 then add using $0: no stall.
- Hazard stall with LOAD_LAT=2 and flush_i in the first stall cycle: stall_o=0 that cycle, ID/EX bubbles, FSM returns to IDLE.
- hold_i for 3 cycles during STALL: all ex_* outputs and cnt frozen; stall resumes afterwards with the remaining count.
- op=111111 three times, one while hold_i=1: illegal_cnt_o=2 and illegal_o=1. err_clr_i coincident with a fourth illegal op gives cnt=1. 300 illegal ops with CNT_W=8 saturate at 255.
- jal: ex_wr_reg_o=31, ex_jal_o=1, ex_jump_o=1, ex_reg_write_o=1. rst_i asserted mid-stall gives all outputs 0 and stall_o=0 immediately (asynchronous).

Source files
------------

// File: rtl/id_ex_ctrl_pipe.sv
// ID-stage main decoder and ID/EX control register with load-use stalling, flush/hold and illegal-opcode tracking.
// Latency: one cycle from ID to ex_* outputs; stall_o is combinational and freezes PC and IF/ID.
module id_ex_ctrl_pipe #(
  parameter int ALU_OP_W = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 8,
  parameter int LINK_REG = 31
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         id_instr_i,
  input  logic                id_valid_i,
  input  logic                flush_i,
  input  logic                hold_i,
  input  logic                err_clr_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic                ex_reg_write_o,
  output logic                ex_alu_src_o,
  output logic                ex_branch_o,
  output logic                ex_jump_o,
  output logic                ex_jal_o,
  output logic                ex_zero_ext_o,
  output logic                ex_lui_o,
  output logic                ex_sltiu_o,
  output logic                ex_mem_to_reg_o,
  output logic                ex_mem_read_o,
  output logic                ex_mem_write_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic [4:0]          ex_shamt_o,
  output logic [4:0]          ex_rs_o,
  output logic [4:0]          ex_rt_o,
  output logic [4:0]          ex_wr_reg_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    illegal_cnt_o
);

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                alu_src;
    logic                branch;
    logic                jump;
    logic                jal;
    logic                zero_ext;
    logic                lui;
    logic                sltiu;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          shamt;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          wr_reg;
  } ctrl_t;

  typedef enum logic {IDLE, STALL} state_t;

  ctrl_t      ex_q, dec, nxt;
  state_t     state;
  logic [1:0] cnt;
  logic       legal, rt_src, hz, stall_act, count_en;
  logic [3:0] aop;
  logic [4:0] rs, rt, rd;
  logic       illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic       unused_funct;

  assign rs = id_instr_i[25:21];
  assign rt = id_instr_i[20:16];
  assign rd = id_instr_i[15:11];
  assign unused_funct = ^id_instr_i[5:0];

  always_comb begin
    dec    = '0;
    aop    = 4'b0000;
    legal  = 1'b1;
    rt_src = 1'b0;
    case (id_instr_i[31:26])
      6'b000000: begin aop = 4'b0000; dec.reg_write = 1'b1; dec.wr_reg = rd; rt_src = 1'b1;
                       dec.shamt = id_instr_i[10:6]; end
      6'b001000: begin aop = 4'b0001; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.wr_reg = rt; end
      6'b000100: begin aop = 4'b0010; dec.branch = 1'b1; rt_src = 1'b1; end
      6'b000101: begin aop = 4'b0011; dec.branch = 1'b1; rt_src = 1'b1; end
      6'b001111: begin aop = 4'b0100; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.lui = 1'b1;
                       dec.wr_reg = rt; end
      6'b001101: begin aop = 4'b0101; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.zero_ext = 1'b1;
                       dec.wr_reg = rt; end
      6'b001011: begin aop = 4'b0110; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.zero_ext = 1'b1;
                       dec.sltiu = 1'b1; dec.wr_reg = rt; end
      6'b000010: begin aop = 4'b0111; dec.jump = 1'b1; end
      6'b000011: begin aop = 4'b1000; dec.jump = 1'b1; dec.jal = 1'b1; dec.reg_write = 1'b1;
                       dec.wr_reg = 5'(LINK_REG); end
      6'b000110: begin aop = 4'b1110; dec.branch = 1'b1; end
      6'b000111: begin aop = 4'b1111; dec.branch = 1'b1; end
      6'b100011: begin aop = 4'b1010; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
                       dec.mem_to_reg = 1'b1; dec.wr_reg = rt; end
      6'b101011: begin aop = 4'b1011; dec.alu_src = 1'b1; dec.mem_write = 1'b1; rt_src = 1'b1; end
      default:   legal = 1'b0;
    endcase
    dec.alu_op = ALU_OP_W'(aop);
    dec.rs     = rs;
    dec.rt     = rt;
    dec.valid  = 1'b1;
    // Invalid or illegal ID contents load as a plain bubble.
    nxt = (id_valid_i && legal) ? dec : '0;
  end

  assign hz = ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != 5'd0) && id_valid_i &&
              ((ex_q.wr_reg == rs) || (rt_src && (ex_q.wr_reg == rt)));

  assign stall_act = (state == STALL) || hz;
  assign stall_o   = !rst_i && !flush_i && (hold_i || stall_act);
  assign count_en  = !flush_i && !hold_i && !stall_act && id_valid_i && !legal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q      <= '0;
      state     <= IDLE;
      cnt       <= 2'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (flush_i) begin
        ex_q  <= '0;
        state <= IDLE;
        cnt   <= 2'd0;
      end else if (hold_i) begin
        // Frozen: pipeline register and stall sequencing keep their values.
      end else if (state == STALL) begin
        ex_q <= '0;
        cnt  <= cnt - 2'd1;
        if (cnt == 2'd1) state <= IDLE;
      end else if (hz) begin
        ex_q <= '0;
        if (LOAD_LAT > 1) begin
          state <= STALL;
          cnt   <= 2'(LOAD_LAT - 1);
        end
      end else begin
        ex_q <= nxt;
      end

      if (err_clr_i) begin
        cnt_q     <= count_en ? CNT_W'(1) : '0;
        illegal_q <= count_en;
      end else if (count_en) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        illegal_q <= 1'b1;
      end
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_jal_o        = ex_q.jal;
  assign ex_zero_ext_o   = ex_q.zero_ext;
  assign ex_lui_o        = ex_q.lui;
  assign ex_sltiu_o      = ex_q.sltiu;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_shamt_o      = ex_q.shamt;
  assign ex_rs_o         = ex_q.rs;
  assign ex_rt_o         = ex_q.rt;
  assign ex_wr_reg_o     = ex_q.wr_reg;
  assign illegal_o       = illegal_q;
  assign illegal_cnt_o   = cnt_q;

endmodule
